y_serializer: RTL and testbench

- Parallel-in, serial-out output buffer for the convolution datapath; the mirror of the serial-write/parallel-read x-vector shift memory.
- Captures a vector of up to SIZE signed results in one cycle, then streams them one word per handshake on a valid/ready output port.
- Sits between the MAC array result vector and the top-level output stream.

---
 rtl/y_serializer.sv | 108 ++++++++++
 tb/tb_y_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/y_serializer.sv
// Parallel-in, serial-out result buffer: captures a vector in one cycle and streams it on valid/ready.
// Optional Y_SERIALIZER_LAST_EN adds m_last, marking the final word of each vector.
module y_serializer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SIZE    = 64,
  parameter int unsigned LOGSIZE = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic signed [WIDTH-1:0] data_in [SIZE-1:0],
  input  logic [LOGSIZE:0]        load_count,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic signed [WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready
`ifdef Y_SERIALIZER_LAST_EN
  ,
  output logic                    m_last
`endif
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  localparam logic [LOGSIZE:0] SizeCnt = (LOGSIZE+1)'(SIZE);
  localparam logic [LOGSIZE:0] CntOne  = (LOGSIZE+1)'(1);

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] buf_q [SIZE-1:0];
  logic signed [WIDTH-1:0] buf_d [SIZE-1:0];
  logic [LOGSIZE:0]        remaining_q, remaining_d;
  logic signed [WIDTH-1:0] m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    transfer, last_xfer, load, load_ok;

  assign transfer   = m_valid_q && m_ready;
  assign last_xfer  = transfer && (remaining_q == CntOne);
  // Final-word transfer reopens the input so the next vector follows with no bubble.
  assign load_ready = reset_n && ((state_q == StIdle) || last_xfer);
  assign load       = load_valid && load_ready;
  assign load_ok    = (load_count != '0) && (load_count <= SizeCnt);

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    remaining_d = remaining_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    if (load && load_ok) begin
      buf_d       = data_in;
      remaining_d = load_count;
      m_data_d    = data_in[0];
      m_valid_d   = 1'b1;
      state_d     = StSend;
    end else if (transfer) begin
      // Invalid loads fall through here, so an end-of-stream one still drains to idle.
      for (int i = 0; i < int'(SIZE) - 1; i++) begin
        buf_d[i] = buf_q[i+1];
      end
      buf_d[SIZE-1] = '0;
      if (remaining_q == CntOne) begin
        remaining_d = '0;
        m_data_d    = '0;
        m_valid_d   = 1'b0;
        state_d     = StIdle;
      end else begin
        remaining_d = remaining_q - CntOne;
        m_data_d    = buf_d[0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      for (int i = 0; i < int'(SIZE); i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      remaining_q <= remaining_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;

`ifdef Y_SERIALIZER_LAST_EN
  logic m_last_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_last_q <= 1'b0;
    end else begin
      m_last_q <= m_valid_d && (remaining_d == CntOne);
    end
  end

  assign m_last = m_last_q;
`endif

endmodule

// File: tb/tb_y_serializer.sv
// Directed self-checking bench for y_serializer at SIZE=4; checks m_last when Y_SERIALIZER_LAST_EN is set.
module tb_y_serializer;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned SIZE    = 4;
  localparam int unsigned LOGSIZE = 2;

  logic                    clk;
  logic                    reset_n;
  logic signed [WIDTH-1:0] data_in [SIZE-1:0];
  logic [LOGSIZE:0]        load_count;
  logic                    load_valid;
  logic                    load_ready;
  logic signed [WIDTH-1:0] m_data;
  logic                    m_valid;
  logic                    m_ready;
`ifdef Y_SERIALIZER_LAST_EN
  logic                    m_last;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  y_serializer #(
    .WIDTH  (WIDTH),
    .SIZE   (SIZE),
    .LOGSIZE(LOGSIZE)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .load_count(load_count),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
`ifdef Y_SERIALIZER_LAST_EN
    ,
    .m_last    (m_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_last(input string tag, input logic exp);
`ifdef Y_SERIALIZER_LAST_EN
    check(tag, m_last, exp);
`endif
  endtask

  // Inputs are driven 1 time unit after the active edge, outputs sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_vec(input int a0, input int a1, input int a2, input int a3, input int cnt);
    data_in[0] = 16'(a0);
    data_in[1] = 16'(a1);
    data_in[2] = 16'(a2);
    data_in[3] = 16'(a3);
    load_count = 3'(cnt);
  endtask

  int exp_w [4];
  int ready_pat [7];
  int idx;

  initial begin
    reset_n    = 1'b0;
    m_ready    = 1'b1;
    load_valid = 1'b0;
    set_vec(0, 0, 0, 0, 0);

    // Reset / idle
    #12;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check_last("rst_m_last", 1'b0);
    #10;
    reset_n = 1'b1;
    #3;
    check("idle_load_ready", load_ready, 1);
    tick();

    // Full vector, m_ready held high
    exp_w = '{10, 20, -3, 40};
    set_vec(10, 20, -3, 40, 4);
    load_valid = 1'b1;
    settle();
    check("full_load_ready", load_ready, 1);
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("full_valid%0d", k), m_valid, 1);
      check($sformatf("full_data%0d", k), m_data, exp_w[k]);
      check($sformatf("full_lr%0d", k), load_ready, (k == 3) ? 1 : 0);
      check_last($sformatf("full_last%0d", k), k == 3);
      tick();
    end
    settle();
    check("full_done_valid", m_valid, 0);
    check("full_done_data", m_data, 0);
    tick();

    // Back-pressure
    ready_pat = '{1, 0, 0, 1, 1, 0, 1};
    set_vec(10, 20, -3, 40, 4);
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      m_ready = ready_pat[c][0];
      settle();
      check($sformatf("bp_valid%0d", c), m_valid, 1);
      check($sformatf("bp_data%0d", c), m_data, exp_w[idx]);
      check($sformatf("bp_lr%0d", c), load_ready, (ready_pat[c] == 1 && idx == 3) ? 1 : 0);
      if (ready_pat[c] == 1) idx++;
      tick();
    end
    m_ready = 1'b1;
    settle();
    check("bp_transfers", idx, 4);
    check("bp_done_valid", m_valid, 0);
    tick();

    // Back-to-back vectors A={1,2}, B={7,8,9}
    set_vec(1, 2, 0, 0, 2);
    load_valid = 1'b1;
    tick();
    set_vec(7, 8, 9, 0, 3);
    settle();
    check("b2b_w1", m_data, 1);
    check("b2b_lr1", load_ready, 0);
    tick();
    settle();
    check("b2b_w2", m_data, 2);
    check("b2b_lr2", load_ready, 1);
    tick();
    load_valid = 1'b0;
    settle();
    check("b2b_w7_valid", m_valid, 1);
    check("b2b_w7", m_data, 7);
    check_last("b2b_last7", 1'b0);
    tick();
    settle();
    check("b2b_w8", m_data, 8);
    check_last("b2b_last8", 1'b0);
    tick();
    settle();
    check("b2b_w9", m_data, 9);
    check("b2b_lr9", load_ready, 1);
    check_last("b2b_last9", 1'b1);
    tick();
    settle();
    check("b2b_done_valid", m_valid, 0);
    tick();

    // Single-word vector
    set_vec(55, 66, 77, 88, 1);
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    settle();
    check("one_valid", m_valid, 1);
    check("one_data", m_data, 55);
    check_last("one_last", 1'b1);
    tick();
    settle();
    check("one_done_valid", m_valid, 0);
    check("one_done_lr", load_ready, 1);
    tick();

    // Invalid loads: count 0 and count 5
    set_vec(11, 12, 13, 14, 0);
    load_valid = 1'b1;
    settle();
    check("inv0_lr", load_ready, 1);
    tick();
    load_valid = 1'b0;
    settle();
    check("inv0_valid", m_valid, 0);
    check("inv0_data", m_data, 0);
    set_vec(11, 12, 13, 14, 5);
    load_valid = 1'b1;
    settle();
    check("inv5_lr", load_ready, 1);
    tick();
    load_valid = 1'b0;
    settle();
    check("inv5_valid", m_valid, 0);
    check("inv5_data", m_data, 0);
    tick();

    // Reset mid-stream with 3 words left
    set_vec(10, 20, -3, 40, 4);
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    settle();
    check("mid_data_before", m_data, 20);
    reset_n = 1'b0;
    settle();
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_data", m_data, 0);
    #3;
    reset_n = 1'b1;
    settle();
    check("mid_rel_lr", load_ready, 1);
    m_ready = 1'b1;
    tick();
    settle();
    check("mid_after_valid", m_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
